// File: rtl/uart_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_mmio
// Purpose  : Memory-mapped UART controller. Captures receiver bytes into an
//            RX FIFO, forwards CPU-written bytes to the sender through a
//            one-byte hold register and a start/busy/done handshake FSM, and
//            exposes TXD/RXD/CON registers plus a registered interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h40000018,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  input  logic        tx_status,
  output logic [7:0]  tx_data,
  output logic        tx_ctrl,
  output logic        irq
);

  localparam int          c_pw       = $clog2(FIFO_DEPTH);
  localparam int          c_cw       = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] c_txd_addr = BASE_ADDR;
  localparam logic [31:0] c_rxd_addr = BASE_ADDR + 32'd4;
  localparam logic [31:0] c_con_addr = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Registered state
  state_t            r_state;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [c_pw-1:0]   r_wptr;
  logic [c_pw-1:0]   r_rptr;
  logic [c_cw-1:0]   r_count;
  logic [7:0]        r_hold;
  logic              r_hold_full;
  logic [7:0]        r_tx_data;
  logic              r_rx_ie;
  logic              r_tx_ie;
  logic              r_rx_ovf;
  logic              r_tx_ovf;
  logic              r_irq;

  // Combinational next-state values
  state_t            w_state_nxt;
  logic [c_cw-1:0]   w_count_nxt;
  logic [7:0]        w_hold_nxt;
  logic              w_hold_full_nxt;
  logic              w_rx_ie_nxt;
  logic              w_tx_ie_nxt;
  logic              w_rx_ovf_nxt;
  logic              w_tx_ovf_nxt;
  logic              w_irq_nxt;

  logic w_hit_txd, w_hit_rxd, w_hit_con;
  logic w_txd_wr, w_con_wr;
  logic w_empty, w_full;
  logic w_pop, w_push_ok;
  logic w_consume;
  logic w_tx_busy;
  logic [31:0] w_con_val;
  logic w_unused_wdata;

  assign w_hit_txd = (addr == c_txd_addr);
  assign w_hit_rxd = (addr == c_rxd_addr);
  assign w_hit_con = (addr == c_con_addr);
  assign w_txd_wr  = mem_write & w_hit_txd;
  assign w_con_wr  = mem_write & w_hit_con;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_cw'(FIFO_DEPTH));
  // A read of an empty FIFO must not disturb the pointers.
  assign w_pop     = mem_read & w_hit_rxd & ~w_empty;
  // When full, a simultaneous pop frees the slot the push needs.
  assign w_push_ok = rx_status & (~w_full | w_pop);

  // Hold register hands its byte to the sender only from IDLE with the sender idle.
  assign w_consume = (r_state == S_IDLE) & r_hold_full & tx_status;
  assign w_tx_busy = (r_state != S_IDLE);

  assign tx_data = r_tx_data;
  assign irq     = r_irq;

  // Upper write-data bits carry no register fields.
  assign w_unused_wdata = ^wdata[31:8];

  assign w_con_val = {20'd0, 4'(r_count), 1'b0, r_tx_ovf, r_rx_ovf,
                      w_tx_busy, r_hold_full, ~w_empty, r_tx_ie, r_rx_ie};

  // TX FSM state register
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // TX FSM next-state and start pulse
  always_comb begin
    w_state_nxt = r_state;
    tx_ctrl     = 1'b0;
    case (r_state)
      S_IDLE:      if (r_hold_full && tx_status) w_state_nxt = S_START;
      S_START: begin
        tx_ctrl     = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!tx_status) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_status)  w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for FIFO count, hold register, control bits and interrupt
  always_comb begin
    w_count_nxt     = r_count;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_rx_ie_nxt     = r_rx_ie;
    w_tx_ie_nxt     = r_tx_ie;
    w_rx_ovf_nxt    = r_rx_ovf;
    w_tx_ovf_nxt    = r_tx_ovf;

    case ({w_push_ok, w_pop})
      2'b10:   w_count_nxt = r_count + c_cw'(1);
      2'b01:   w_count_nxt = r_count - c_cw'(1);
      default: w_count_nxt = r_count;
    endcase

    if (w_consume) w_hold_full_nxt = 1'b0;
    if (w_txd_wr) begin
      // A byte leaving the hold register this cycle makes room for the new one.
      if (!r_hold_full || w_consume) begin
        w_hold_nxt      = wdata[7:0];
        w_hold_full_nxt = 1'b1;
      end else begin
        w_tx_ovf_nxt    = 1'b1;
      end
    end

    if (w_con_wr) begin
      w_rx_ie_nxt = wdata[0];
      w_tx_ie_nxt = wdata[1];
      if (wdata[5]) w_rx_ovf_nxt = 1'b0;
      if (wdata[6]) w_tx_ovf_nxt = 1'b0;
    end
    // A new overflow beats a simultaneous clear so the event is never lost.
    if (rx_status && w_full && !w_pop) w_rx_ovf_nxt = 1'b1;

    w_irq_nxt = (w_rx_ie_nxt & (w_count_nxt != '0)) |
                (w_tx_ie_nxt & ~w_hold_full_nxt & (w_state_nxt == S_IDLE));
  end

  // Control, hold and interrupt registers
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_tx_data   <= 8'd0;
      r_rx_ie     <= 1'b0;
      r_tx_ie     <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      if (w_push_ok) r_wptr <= r_wptr + c_pw'(1);
      if (w_pop)     r_rptr <= r_rptr + c_pw'(1);
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      // tx_data only changes when a byte is launched, so it is stable for the frame.
      if (w_consume) r_tx_data <= r_hold;
      r_rx_ie     <= w_rx_ie_nxt;
      r_tx_ie     <= w_tx_ie_nxt;
      r_rx_ovf    <= w_rx_ovf_nxt;
      r_tx_ovf    <= w_tx_ovf_nxt;
      r_irq       <= w_irq_nxt;
    end
  end

  // RX FIFO storage
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'd0;
    end else if (w_push_ok) begin
      r_mem[r_wptr] <= rx_data;
    end
  end

  // Read data mux, purely address driven
  always_comb begin
    rdata = 32'd0;
    if (w_hit_txd)      rdata = {24'd0, r_hold};
    else if (w_hit_rxd) rdata = w_empty ? 32'd0 : {24'd0, r_mem[r_rptr]};
    else if (w_hit_con) rdata = w_con_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_mmio
// Purpose  : Scoreboard bench for uart_mmio with a behavioural sender model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;

  localparam logic [31:0] c_txd = 32'h40000018;
  localparam logic [31:0] c_rxd = 32'h4000001C;
  localparam logic [31:0] c_con = 32'h40000020;

  localparam logic [1:0] c_sel_irq  = 2'd0;
  localparam logic [1:0] c_sel_ctrl = 2'd1;
  localparam logic [1:0] c_sel_txd  = 2'd2;
  localparam logic [1:0] c_sel_rd   = 2'd3;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] val;
  } chk_t;

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  rx_data;
  logic        rx_status;
  logic        tx_status;
  logic [7:0]  tx_data;
  logic        tx_ctrl;
  logic        irq;

  logic        in_reset;
  logic        rand_status;
  logic        model_status;
  logic        done;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  tx_exp_q [$];
  chk_t        chk_q [$];
  chk_t        mon_c;
  logic [31:0] mon_e;
  logic [31:0] mon_act;
  logic [7:0]  mon_b;
  logic        mon_prev_ctrl = 1'b0;

  assign tx_status = in_reset ? rand_status : model_status;

  always #5 sysclk = ~sysclk;

  uart_mmio dut (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .addr      (addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .wdata     (wdata),
    .rdata     (rdata),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .tx_status (tx_status),
    .tx_data   (tx_data),
    .tx_ctrl   (tx_ctrl),
    .irq       (irq)
  );

  // Sender model: drops idle 10 cycles after a start pulse, raises it 100 later
  initial begin
    model_status = 1'b1;
    forever begin
      @(negedge sysclk);
      if (tx_ctrl && reset_n && !in_reset) begin
        repeat (10) @(posedge sysclk);
        #1 model_status = 1'b0;
        repeat (100) @(posedge sysclk);
        #1 model_status = 1'b1;
      end
    end
  end

  // Monitor: sole owner of the counters; checks reads, tx pulses and direct checks
  always @(negedge sysclk) begin
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      tests++;
      case (mon_c.sel)
        c_sel_irq:  mon_act = {31'd0, irq};
        c_sel_ctrl: mon_act = {31'd0, tx_ctrl};
        c_sel_txd:  mon_act = {24'd0, tx_data};
        default:    mon_act = rdata;
      endcase
      if (mon_act !== mon_c.val) begin
        fails++;
        $display("FAIL direct_sel%0d t=%0t actual=%h required=%h", mon_c.sel, $time, mon_act, mon_c.val);
      end
    end
    if (reset_n && mem_read) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected addr=%h actual=%h required=none", addr, rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rdata !== mon_e) begin
          fails++;
          $display("FAIL rd addr=%h t=%0t actual=%h required=%h", addr, $time, rdata, mon_e);
        end
      end
    end
    if (reset_n && mon_prev_ctrl) begin
      tests++;
      if (tx_ctrl !== 1'b0) begin
        fails++;
        $display("FAIL tx_ctrl_width t=%0t actual=%b required=0", $time, tx_ctrl);
      end
    end
    if (reset_n && tx_ctrl) begin
      tests++;
      if (tx_exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected tx_data=%h required=none", tx_data);
      end else begin
        mon_b = tx_exp_q.pop_front();
        if (tx_data !== mon_b) begin
          fails++;
          $display("FAIL tx_data t=%0t actual=%h required=%h", $time, tx_data, mon_b);
        end
      end
    end
    mon_prev_ctrl = reset_n & tx_ctrl;
    if (done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL rd_leftover actual=%0d required=0", exp_q.size());
      end
      tests++;
      if (tx_exp_q.size() != 0) begin
        fails++;
        $display("FAIL tx_leftover actual=%0d required=0", tx_exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic expect_now(input logic [1:0] sel, input logic [31:0] val);
    chk_t c;
    c.sel = sel;
    c.val = val;
    chk_q.push_back(c);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; addr = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
    addr = a; mem_read = 1'b1;
    exp_q.push_back(e);
    tick();
    mem_read = 1'b0; addr = 32'd0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_status = 1'b1;
    tick();
    rx_status = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    done = 1'b0; in_reset = 1'b1; rand_status = 1'b0;
    reset_n = 1'b0; addr = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
    wdata = 32'd0; rx_data = 8'd0; rx_status = 1'b0;

    // Reset held with random activity on every input
    for (int i = 0; i < 6; i++) begin
      tick();
      addr      = (i % 2 == 0) ? c_txd : $urandom;
      wdata     = $urandom;
      mem_write = 1'($urandom_range(0, 1));
      mem_read  = 1'($urandom_range(0, 1));
      rx_data   = 8'($urandom);
      rx_status = 1'($urandom_range(0, 1));
      rand_status = 1'($urandom_range(0, 1));
    end
    addr = c_con;
    expect_now(c_sel_rd, 32'd0);
    expect_now(c_sel_ctrl, 32'd0);
    expect_now(c_sel_irq, 32'd0);
    tick();
    mem_read = 1'b0; mem_write = 1'b0; rx_status = 1'b0;
    in_reset = 1'b0; reset_n = 1'b1;
    tick(); tick();
    expect_now(c_sel_rd, 32'd0);
    expect_now(c_sel_irq, 32'd0);
    expect_now(c_sel_ctrl, 32'd0);
    bus_read(c_con, 32'd0);

    // RX path
    rx_push(8'h41);
    rx_push(8'h42);
    bus_read(c_con, 32'h0000_0204);
    bus_read(c_rxd, 32'h41);
    bus_read(c_rxd, 32'h42);
    bus_read(c_con, 32'h0);
    bus_read(c_rxd, 32'h0);

    // RX overflow and clear
    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    bus_read(c_con, 32'h0000_0424);
    for (int i = 1; i <= 4; i++) bus_read(c_rxd, 32'(i));
    bus_read(c_con, 32'h20);
    bus_write(c_con, 32'h20);
    bus_read(c_con, 32'h0);
    for (int i = 0; i < 4; i++) rx_push(8'(8'h11 + i));
    // Push and pop together while full
    rx_data = 8'h15; rx_status = 1'b1; addr = c_rxd; mem_read = 1'b1;
    exp_q.push_back(32'h11);
    tick();
    rx_status = 1'b0; mem_read = 1'b0;
    bus_read(c_con, 32'h0000_0404);
    for (int i = 0; i < 4; i++) bus_read(c_rxd, 32'(8'h12 + i));
    bus_read(c_con, 32'h0);

    // TX handshake
    tx_exp_q.push_back(8'h55);
    bus_write(c_txd, 32'h55);
    expect_now(c_sel_ctrl, 32'd0);
    tick();
    expect_now(c_sel_ctrl, 32'd1);
    expect_now(c_sel_txd, 32'h55);
    tick();
    expect_now(c_sel_ctrl, 32'd0);
    repeat (3) tick();
    bus_read(c_con, 32'h10);
    repeat (30) tick();
    bus_read(c_con, 32'h10);
    expect_now(c_sel_txd, 32'h55);
    repeat (100) tick();
    bus_read(c_con, 32'h0);

    // TX overflow while busy
    tx_exp_q.push_back(8'h33);
    bus_write(c_txd, 32'h33);
    repeat (5) tick();
    bus_write(c_txd, 32'hA0);
    bus_read(c_con, 32'h18);
    bus_write(c_txd, 32'hA1);
    bus_read(c_con, 32'h58);
    bus_read(c_txd, 32'hA0);
    tx_exp_q.push_back(8'hA0);
    repeat (260) tick();
    bus_read(c_con, 32'h40);
    bus_write(c_con, 32'h40);
    bus_read(c_con, 32'h0);

    // Interrupts
    bus_write(c_con, 32'h1);
    expect_now(c_sel_irq, 32'd0);
    rx_push(8'h77);
    expect_now(c_sel_irq, 32'd1);
    bus_read(c_rxd, 32'h77);
    expect_now(c_sel_irq, 32'd0);
    bus_write(c_con, 32'h2);
    expect_now(c_sel_irq, 32'd1);
    tx_exp_q.push_back(8'h99);
    bus_write(c_txd, 32'h99);
    expect_now(c_sel_irq, 32'd0);
    repeat (250) tick();
    expect_now(c_sel_irq, 32'd1);

    done = 1'b1;
    repeat (4) @(posedge sysclk);
    $display("FAIL monitor_stalled actual=running required=finished");
    $fatal(1, "monitor did not finish");
  end

endmodule
`default_nettype wire

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART controller between the CPU data bus and the UART receiver/sender pair.
- Downstream of the receiver: it captures each byte flagged by the receiver's one-cycle rx_status pulse into an RX FIFO.
- Upstream of the sender: it holds a CPU-written byte, drives tx_data stable and pulses tx_ctrl, then tracks tx_status to completion.
- Provides TXD/RXD/CON registers and a registered interrupt.

Parameters:
BASE_ADDR, 32'h40000018, byte address of TXD; RXD = BASE_ADDR+4, CON = BASE_ADDR+8
FIFO_DEPTH, 4, RX FIFO entries; power of two, 2..8

Ports:
sysclk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
addr  input  32  bus byte address (full compare against the three register addresses)
mem_read  input  1  bus read strobe
mem_write  input  1  bus write strobe
wdata  input  32  bus write data
rdata  output  32  read data, combinational from addr; 0 when addr does not hit
rx_data  input  8  byte from receiver
rx_status  input  1  receiver byte-valid, one sysclk pulse
tx_status  input  1  sender idle (1) / busy (0)
tx_data  output  8  byte to sender
tx_ctrl  output  1  sender start request, one-cycle pulse
irq  output  1  registered interrupt request

Behaviour:
Reset (async, reset_n=0):
- FIFO empty, count 0; hold register 0, hold_full 0; tx_data 0; tx_ctrl 0; irq 0.
- All CON enables and sticky flags 0; FSM in IDLE.

Register map:
- TXD write: hold <= wdata[7:0], hold_full <= 1. If hold_full is already 1 and is not being consumed this cycle, the write is dropped and tx_ovf <= 1.
- TXD read: {24'b0, hold}.
- RXD read: {24'b0, FIFO head}; pops at the clock edge. An empty read returns 0, does not pop, and changes no state.
- CON read: [0] rx_ie, [1] tx_ie, [2] rx_nonempty, [3] hold_full, [4] tx_busy (FSM != IDLE), [5] rx_ovf, [6] tx_ovf, [11:8] rx_count, all other bits 0.
- CON write: bits[1:0] load rx_ie/tx_ie. Bits 5 and 6 are write-1-to-clear. Other bits are ignored.
- mem_read and mem_write asserted together: both take effect.

RX FIFO:
- Push rx_data on any cycle with rx_status=1.
- Push while full: byte dropped, FIFO unchanged, rx_ovf <= 1.
- Push and pop in the same cycle: both occur, count unchanged. When full this is accepted with no overflow.
- Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

TX FSM:
- IDLE: if hold_full and tx_status=1, go to START and latch tx_data <= hold, hold_full <= 0. A TXD write in this same cycle is accepted as a new hold value with no overflow.
- START: tx_ctrl=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: stay until tx_status=0, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_status=1, then go to IDLE.
- tx_data is held constant from START until back in IDLE.
- The minimum gap between consecutive tx_ctrl pulses is one full sender frame.

irq:
- Registered next-state value: (rx_ie & rx_nonempty) | (tx_ie & ~hold_full & ~tx_busy).
- One cycle latency from the causing event.

Reset mid-frame:
- FSM returns to IDLE and tx_ctrl drops immediately.
- The sender is not reset by this block; the next START waits for tx_status=1.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> rdata of CON = 0, tx_ctrl=0, irq=0. Release reset -> still 0 until stimulated.
- RX path: pulse rx_status with 8'h41 then 8'h42 -> CON[11:8]=2, CON[2]=1. Two RXD reads return 32'h41 then 32'h42. CON[2]=0 afterwards, and a third RXD read returns 0.
- RX overflow, FIFO_DEPTH=4: push 5 bytes 8'h01..8'h05 -> CON[5]=1, count=4, pops yield 01..04. Write CON with 32'h20 -> CON[5]=0. Push and pop in the same cycle while full -> count stays 4, no overflow.
- TX handshake: write TXD 32'h55 with tx_status=1 -> tx_ctrl pulses exactly one cycle, two cycles after the write, with tx_data=8'h55. Model sender drops tx_status 10 cycles later and raises it 100 cycles after that -> CON[4]=1 throughout, 0 after.
- TX overflow: while busy, write TXD 8'hA0 (accepted, CON[3]=1), then 8'hA1 -> tx_ovf=1 and hold stays A0. After the first frame completes, a second tx_ctrl pulse occurs with tx_data=8'hA0.
- irq: set CON=32'h1, push one byte -> irq rises one cycle after the push; RXD read -> irq falls one cycle later. Set CON=32'h2 while idle with hold empty -> irq=1 one cycle later.
